// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the byte-addressed data memory controller:
//   - RV32I load/store funct3 width/sign codes
//   - FSM state encodings (plain localparams so older tools can consume them)
//   - width of the wait-state counter
//   - helper that flags funct3 codes with no load/store meaning
// -----------------------------------------------------------------------------
package dmem_pkg;

    // RV32I load/store width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access FSM states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Wait-state counter width; WAIT_CYC must fit (0..15)
    localparam int CNT_W = 4;

    // 011, 110 and 111 are not load/store width codes
    function automatic logic is_illegal_f3(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_lane_ctrl
// Purely combinational byte-lane steering for the data memory.
//   funct3_i     : RV32I width/sign code of the access
//   lane_i       : byte address bits [1:0]
//   wd_i         : right-aligned store data
//   rword_i      : raw 32-bit word read from the RAM
//   be_o         : per-byte write enables (lane 0 = bits 7:0)
//   wdata_o      : store data replicated onto every lane; be_o picks lanes
//   rdata_o      : sign/zero-extended load result
//   illegal_o    : funct3 is not a load/store code
//   misaligned_o : halfword/word access not naturally aligned (trap build)
// Build option: DMEM_MISALIGN_TRAP_EN makes misaligned H/W accesses trap;
// without it, low address bits are ignored to force alignment.
// -----------------------------------------------------------------------------
module dmem_lane_ctrl
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        illegal_o,
    output logic        misaligned_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign illegal_o = is_illegal_f3(funct3_i);

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        misaligned_o = 1'b0;
        if (!illegal_o) begin
            unique case (funct3_i[1:0])
                2'b01:   misaligned_o = lane_i[0];
                2'b10:   misaligned_o = (lane_i != 2'b00);
                default: misaligned_o = 1'b0;
            endcase
        end
    end
`else
    // Low bits are simply ignored below, so nothing is ever misaligned.
    assign misaligned_o = 1'b0;
`endif

    // Store side: bits [1:0] of funct3 give the width for SB/SH/SW.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wd_i;
        unique case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wd_i[7:0]}};
            end
            2'b01: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wd_i[15:0]}};
            end
            2'b10: begin
                be_o    = 4'b1111;
                wdata_o = wd_i;
            end
            default: be_o = 4'b0000;
        endcase
    end

    // Load side: pick the addressed byte/halfword, then extend.
    always_comb begin
        rd_byte = rword_i[7:0];
        unique case (lane_i)
            2'd0: rd_byte = rword_i[7:0];
            2'd1: rd_byte = rword_i[15:8];
            2'd2: rd_byte = rword_i[23:16];
            2'd3: rd_byte = rword_i[31:24];
        endcase
        rd_half = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

        rdata_o = 32'h0;
        unique case (funct3_i)
            F3_B:    rdata_o = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    rdata_o = {{16{rd_half[15]}}, rd_half};
            F3_W:    rdata_o = rword_i;
            F3_BU:   rdata_o = {24'h0, rd_byte};
            F3_HU:   rdata_o = {16'h0, rd_half};
            default: rdata_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Byte-addressed data RAM with RV32I SB/SH/SW stores and LB/LH/LW/LBU/LHU
// loads behind a req/ready/rvalid handshake with WAIT_CYC wait states.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (RAM contents are kept)
//   req     : access request, taken when ready=1
//   WE      : 1 = store, 0 = load (latched with req)
//   funct3  : RV32I width/sign code (latched with req)
//   Address : byte address (latched with req)
//   WD      : right-aligned store data (latched with req)
//   ready   : block is idle and will take req this cycle
//   rvalid  : one-cycle completion pulse for loads and stores
//   RD      : registered, extended load result; held between pulses
//   err     : qualifies rvalid; illegal funct3 or trapped misalignment
// Parameters: ADDR_W (byte address width, depth 2**(ADDR_W-2) words),
//             WAIT_CYC (0..15 busy cycles per access).
// Build option: DMEM_MISALIGN_TRAP_EN (see dmem_lane_ctrl).
// -----------------------------------------------------------------------------
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              WE,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WD,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       RD,
    output logic              err
);

    localparam int              DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYC);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wd_q, wd_d;
    logic [31:0]       rd_q, rd_d;
    logic              err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    // Fields of the access being committed this edge. With WAIT_CYC=0 the
    // commit happens on the accept edge itself, so the live inputs are used
    // before they reach the latches.
    logic              acc_we;
    logic [2:0]        acc_f3;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wd;
    logic [ADDR_W-3:0] word_idx;
    logic              commit;
    logic              wr_en;

    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        illegal;
    logic        misaligned;

    assign acc_we   = (state_q == IDLE) ? WE      : we_q;
    assign acc_f3   = (state_q == IDLE) ? funct3  : f3_q;
    assign acc_addr = (state_q == IDLE) ? Address : addr_q;
    assign acc_wd   = (state_q == IDLE) ? WD      : wd_q;
    assign word_idx = acc_addr[ADDR_W-1:2];

    // The edge that enters DONE is the one that touches the RAM and RD/err.
    assign commit = ((state_q == IDLE) && req && (WAIT_CYC == 0))
                 || ((state_q == BUSY) && (cnt_q == CNT_W'(1)));

    // rst_n gates the write so a request held during reset cannot slip a
    // zero-wait store into the RAM, which itself has no reset.
    assign wr_en = commit && acc_we && !illegal && !misaligned && rst_n;

    dmem_lane_ctrl u_lane (
        .funct3_i     (acc_f3),
        .lane_i       (acc_addr[1:0]),
        .wd_i         (acc_wd),
        .rword_i      (mem_q[word_idx]),
        .be_o         (be),
        .wdata_o      (wdata),
        .rdata_o      (rdata),
        .illegal_o    (illegal),
        .misaligned_o (misaligned)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d   = WE;
                    f3_d   = funct3;
                    addr_d = Address;
                    wd_d   = WD;
                    if (WAIT_CYC == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (commit) begin
            if (illegal || misaligned) begin
                rd_d  = 32'h0;
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
                if (!acc_we) begin
                    rd_d = rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wd_q    <= 32'h0;
            rd_q    <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the RAM array has no reset; clearing it would turn it into
    // thousands of flops instead of a RAM macro, and contents must survive
    // a reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign ready  = (state_q == IDLE);
    assign rvalid = (state_q == DONE);
    assign RD     = rd_q;
    assign err    = err_q;

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised successor to the processor's word-only data memory. Byte-addressed RAM with RV32I load/store widths: SB/SH/SW stores with byte-lane enables, and LB/LH/LW/LBU/LHU loads with sign or zero extension. Every access goes through a req/ready/rvalid handshake with a configurable wait-state counter, so a slower memory model can later replace this block without changing the LSU side. Sits between the datapath's ALU result/rs2 and the writeback mux.

Parameters:
ADDR_W, 10, byte-address width; depth = 2**(ADDR_W-2) 32-bit words
WAIT_CYC, 0, extra busy cycles per access (0..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  access request, sampled when ready=1
WE  input  1  1 = store, 0 = load; latched with req
funct3  input  3  RV32I width/sign code; latched with req
Address  input  ADDR_W  byte address; latched with req
WD  input  32  store data, right-aligned; latched with req
ready  output  1  block can accept req this cycle
rvalid  output  1  one-cycle response pulse, for loads and stores
RD  output  32  load result, registered, extended to 32 bits
err  output  1  qualifies rvalid; illegal funct3 or trapped misalignment

Behaviour:
- Reset: state IDLE, ready=1, rvalid=0, RD=0, err=0, wait counter=0. RAM contents are not reset.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ready=1. On req=1 at a clock edge, latch WE, funct3, Address and WD. Go to BUSY with counter=WAIT_CYC, or go directly to DONE if WAIT_CYC=0.
  - BUSY: ready=0. Counter decrements each edge. At the edge where counter=1, go to DONE.
  - DONE: ready=0, rvalid=1 for exactly one cycle, then IDLE.
- RAM access timing: the RAM write and the RD/err update occur on the edge that enters DONE.
  - Latency is WAIT_CYC+1 cycles from the accept edge to rvalid.
  - Throughput is one access per WAIT_CYC+2 cycles.
  - A req arriving while ready=0 is ignored; the requester holds it.
- Lanes: word index = Address[ADDR_W-1:2]; lane = Address[1:0].
- Stores:
  - 000 SB writes byte WD[7:0] to the addressed lane.
  - 001 SH writes WD[15:0] to lanes {Address[1],0} and {Address[1],1}.
  - 010 SW writes the full word.
  - Unwritten lanes keep their value.
  - RD is unchanged on stores.
- Loads:
  - 000 LB and 001 LH sign-extend.
  - 100 LBU and 101 LHU zero-extend.
  - 010 LW returns the word.
- Illegal funct3 (011, 110, 111): no write, RD=0, err=1 with rvalid.
- err=0 on all legal accesses. err and RD hold their values between rvalid pulses.
- Reset asserted mid-access: return to IDLE immediately. A store not yet committed is dropped; no partial write.
- Back-to-back store then load to the same address: the load returns the stored data, because accesses are serialised.
- Address range is exactly the depth, so no out-of-range case exists.

Optional Feature:
Macro DMEM_MISALIGN_TRAP_EN.
- Defined: SH/LH/LHU with Address[0]=1, or SW/LW with Address[1:0]!=0, is a misaligned access. It completes with err=1, no write and RD=0.
- Not defined: low address bits are ignored to force alignment. Halfword accesses use Address[1] only; word accesses ignore Address[1:0]. err is raised only for illegal funct3.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - state encodings IDLE=0, BUSY=1, DONE=2
  - width of the WAIT_CYC counter (4)
- One combinational sub-module, dmem_lane_ctrl, maps funct3/Address[1:0]/WD to:
  - a 4-bit byte-enable and the lane-shifted write word
  - the extended load result from the raw word
  - the illegal/misaligned flags
- The FSM, counter and RAM stay in dmem_ctrl.

Test Plan:
1. WAIT_CYC=0. SW 0xDEADBEEF @0x10, then LW @0x10 -> rvalid 1 cycle after each accept, RD=0xDEADBEEF, err=0.
2. SB 0x80 @0x13 over 0x00000000, then LB @0x13 -> RD=0xFFFFFF80. LBU @0x13 -> RD=0x00000080. LW @0x10 -> RD=0x80000000.
3. WAIT_CYC=3. LH @0x22 after SW 0x8001_7FFF @0x20 -> ready=0 for 4 cycles, rvalid on the 4th cycle after accept, RD=0xFFFF8001. Also assert a req during BUSY and confirm it is ignored.
4. funct3=011 load @0x0 -> rvalid=1, err=1, RD=0. funct3=111 store -> no RAM change, checked by a following LW.
5. Misaligned SW 0x12345678 @0x31:
   - with DMEM_MISALIGN_TRAP_EN: err=1 and word 0x30 unchanged
   - without it: err=0 and LW @0x30 -> 0x12345678
6. WAIT_CYC=3. Drop rst_n during BUSY of SW 0xFFFFFFFF @0x40 -> state returns to IDLE, ready=1, rvalid=0, and a subsequent LW @0x40 returns the old value.
